// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU sequencer slice: default parameter values
// and the sequencer state encoding.
package tpu_pkg;

  localparam int DATAWIDTH_DEF  = 16;
  localparam int ARRAY_SIZE_DEF = 4;
  localparam int ADDR_W_DEF     = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FIRE,
    ST_WAIT,
    ST_WB,
    ST_DONE
  } state_t;

endpackage

// File: rtl/tpu_row_packer.sv
// Row assembly for the systolic array load path.
// Delays the read strobe by the SRAM read latency, drops each returning word
// into its slot of the packed activation or weight row, and raises o_valid
// for one cycle once the last weight word of a row has been captured.
//   i_rd_en / i_rd_pos : a read was issued this cycle; pos 0..N-1 = activation
//                        word j, pos N..2N-1 = weight word j-N
//   i_rdata            : SRAM read data (1-cycle latency)
//   o_valid            : registered one-cycle row-pair valid
//   o_act_row/o_wgt_row: packed rows, word j at [j*DATAWIDTH +: DATAWIDTH]
module tpu_row_packer
  import tpu_pkg::*;
#(
  parameter int DATAWIDTH  = DATAWIDTH_DEF,
  parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
  localparam int POS_W     = $clog2(2 * ARRAY_SIZE)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_rd_en,
  input  logic [POS_W-1:0]                i_rd_pos,
  input  logic [DATAWIDTH-1:0]            i_rdata,
  output logic                            o_valid,
  output logic [ARRAY_SIZE*DATAWIDTH-1:0] o_act_row,
  output logic [ARRAY_SIZE*DATAWIDTH-1:0] o_wgt_row
);

  localparam int unsigned N = ARRAY_SIZE;

  logic                            r_cap_en;
  logic [POS_W-1:0]                r_cap_pos;
  logic                            r_valid;
  logic [ARRAY_SIZE*DATAWIDTH-1:0] r_act_row;
  logic [ARRAY_SIZE*DATAWIDTH-1:0] r_wgt_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_en  <= 1'b0;
      r_cap_pos <= '0;
      r_valid   <= 1'b0;
      r_act_row <= '0;
      r_wgt_row <= '0;
    end else begin
      r_cap_en  <= i_rd_en;
      r_cap_pos <= i_rd_pos;
      r_valid   <= r_cap_en && (r_cap_pos == POS_W'(2 * N - 1));
      if (r_cap_en) begin
        for (int unsigned j = 0; j < N; j++) begin
          if (r_cap_pos == POS_W'(j))
            r_act_row[j*DATAWIDTH +: DATAWIDTH] <= i_rdata;
          if (r_cap_pos == POS_W'(N + j))
            r_wgt_row[j*DATAWIDTH +: DATAWIDTH] <= i_rdata;
        end
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_act_row = r_act_row;
  assign o_wgt_row = r_wgt_row;

endmodule

// File: rtl/tpu_sequencer.sv
// Command sequencer between a host, a single-port SRAM and an N x N systolic
// array. Per tile: stream activation/weight rows out of SRAM into the array,
// fire it, wait for completion, then write the N*N result words back.
//   start, *_base, num_tiles : command, sampled when accepted in IDLE
//   host_*                   : host SRAM port, passed through only in IDLE
//   sram_*                   : SRAM port (read data 1-cycle latency)
//   arr_*                    : systolic array load/start/done/result
//   busy / done / err        : not-IDLE, completion pulse, sticky host collision
module tpu_sequencer
  import tpu_pkg::*;
#(
  parameter int DATAWIDTH  = DATAWIDTH_DEF,
  parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [ADDR_W-1:0]                          act_base,
  input  logic [ADDR_W-1:0]                          wgt_base,
  input  logic [ADDR_W-1:0]                          out_base,
  input  logic [7:0]                                 num_tiles,
  input  logic                                       host_we,
  input  logic [ADDR_W-1:0]                          host_addr,
  input  logic [DATAWIDTH-1:0]                       host_wdata,
  output logic [DATAWIDTH-1:0]                       host_rdata,
  output logic [ADDR_W-1:0]                          sram_addr,
  output logic                                       sram_we,
  output logic [DATAWIDTH-1:0]                       sram_wdata,
  input  logic [DATAWIDTH-1:0]                       sram_rdata,
  output logic                                       arr_load_valid,
  output logic [ARRAY_SIZE*DATAWIDTH-1:0]            arr_act_row,
  output logic [ARRAY_SIZE*DATAWIDTH-1:0]            arr_wgt_row,
  output logic                                       arr_start,
  input  logic                                       arr_done,
  input  logic [ARRAY_SIZE*ARRAY_SIZE*DATAWIDTH-1:0] arr_result,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       err
);

  localparam int unsigned N        = ARRAY_SIZE;
  localparam int unsigned NN       = N * N;
  localparam int unsigned RD_CYC   = 2 * NN;      // one SRAM read per cycle
  localparam int unsigned LOAD_CYC = RD_CYC + 2;  // + read latency + packer register
  localparam int          CNT_W    = $clog2(LOAD_CYC);
  localparam int          POS_W    = $clog2(2 * N);

  state_t                 r_state, w_next;
  logic [7:0]             r_num_tiles, r_tile;
  logic [ADDR_W-1:0]      r_act_tile, r_wgt_base, r_out_tile, r_row_off;
  logic [POS_W-1:0]       r_pos;
  logic [CNT_W-1:0]       r_cnt;
  logic [NN*DATAWIDTH-1:0] r_result;
  logic                   r_err, r_done;
  logic                   w_accept, w_rd_en, w_load_last, w_wb_last, w_more;

  assign w_accept    = start && (r_state == ST_IDLE);
  assign w_rd_en     = (r_state == ST_LOAD) && (r_cnt < CNT_W'(RD_CYC));
  assign w_load_last = (r_cnt == CNT_W'(LOAD_CYC - 1));
  assign w_wb_last   = (r_cnt == CNT_W'(NN - 1));
  assign w_more      = (r_tile + 8'd1) < r_num_tiles;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_next = (num_tiles == 8'd0) ? ST_DONE : ST_LOAD;
      ST_LOAD: if (w_load_last) w_next = ST_FIRE;
      ST_FIRE: w_next = ST_WAIT;
      ST_WAIT: if (arr_done) w_next = ST_WB;
      ST_WB:   if (w_wb_last) w_next = w_more ? ST_LOAD : ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // SRAM port mux: host in IDLE, row reads in LOAD, result writes in WB.
  always_comb begin
    sram_addr  = '0;
    sram_we    = 1'b0;
    sram_wdata = '0;
    unique case (r_state)
      ST_IDLE: begin
        sram_addr  = host_addr;
        sram_we    = host_we;
        sram_wdata = host_wdata;
      end
      ST_LOAD: begin
        if (w_rd_en) begin
          if (r_pos < POS_W'(N))
            sram_addr = r_act_tile + r_row_off + ADDR_W'(r_pos);
          else
            sram_addr = r_wgt_base + r_row_off + ADDR_W'(r_pos) - ADDR_W'(N);
        end
      end
      ST_WB: begin
        sram_addr = r_out_tile + ADDR_W'(r_cnt);
        sram_we   = 1'b1;
        for (int unsigned i = 0; i < NN; i++)
          if (r_cnt == CNT_W'(i)) sram_wdata = r_result[i*DATAWIDTH +: DATAWIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Per-tile bases advance by N*N after each write-back so no multiply is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_tiles <= '0;
      r_tile      <= '0;
      r_act_tile  <= '0;
      r_wgt_base  <= '0;
      r_out_tile  <= '0;
    end else if (w_accept) begin
      r_num_tiles <= num_tiles;
      r_tile      <= '0;
      r_act_tile  <= act_base;
      r_wgt_base  <= wgt_base;
      r_out_tile  <= out_base;
    end else if ((r_state == ST_WB) && w_wb_last) begin
      r_tile     <= r_tile + 8'd1;
      r_act_tile <= r_act_tile + ADDR_W'(NN);
      r_out_tile <= r_out_tile + ADDR_W'(NN);
    end
  end

  // r_cnt restarts on every state change; it times both LOAD and WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_pos     <= '0;
      r_row_off <= '0;
    end else begin
      if (w_next != r_state) r_cnt <= '0;
      else                   r_cnt <= r_cnt + CNT_W'(1);
      if (r_state != ST_LOAD) begin
        r_pos     <= '0;
        r_row_off <= '0;
      end else if (w_rd_en) begin
        if (r_pos == POS_W'(2 * N - 1)) begin
          r_pos     <= '0;
          r_row_off <= r_row_off + ADDR_W'(N);
        end else begin
          r_pos <= r_pos + POS_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if ((r_state == ST_WAIT) && arr_done) r_result <= arr_result;
      if (w_accept)                          r_err <= 1'b0;
      else if ((r_state != ST_IDLE) && host_we) r_err <= 1'b1;
      r_done <= (r_state == ST_DONE);
    end
  end

  tpu_row_packer #(
    .DATAWIDTH (DATAWIDTH),
    .ARRAY_SIZE(ARRAY_SIZE)
  ) u_row_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_rd_en  (w_rd_en),
    .i_rd_pos (r_pos),
    .i_rdata  (sram_rdata),
    .o_valid  (arr_load_valid),
    .o_act_row(arr_act_row),
    .o_wgt_row(arr_wgt_row)
  );

  assign host_rdata = sram_rdata;
  assign arr_start  = (r_state == ST_FIRE);
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_tpu_sequencer.sv
module tb_tpu_sequencer;

  localparam int DW    = 16;
  localparam int N     = 2;
  localparam int AW    = 10;
  localparam int NN    = N * N;
  localparam int RD    = 2 * NN;
  localparam int LOADC = RD + 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [AW-1:0]     act_base = '0, wgt_base = '0, out_base = '0;
  logic [7:0]        num_tiles = '0;
  logic              host_we = 1'b0;
  logic [AW-1:0]     host_addr = '0;
  logic [DW-1:0]     host_wdata = '0;
  logic [DW-1:0]     host_rdata;
  logic [AW-1:0]     sram_addr;
  logic              sram_we;
  logic [DW-1:0]     sram_wdata;
  logic [DW-1:0]     sram_rdata;
  logic              arr_load_valid;
  logic [N*DW-1:0]   arr_act_row, arr_wgt_row;
  logic              arr_start;
  logic              arr_done = 1'b0;
  logic [NN*DW-1:0]  arr_result = '0;
  logic              busy, done, err;

  tpu_sequencer #(.DATAWIDTH(DW), .ARRAY_SIZE(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .act_base(act_base), .wgt_base(wgt_base), .out_base(out_base), .num_tiles(num_tiles),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .sram_addr(sram_addr), .sram_we(sram_we), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .arr_load_valid(arr_load_valid), .arr_act_row(arr_act_row), .arr_wgt_row(arr_wgt_row),
    .arr_start(arr_start), .arr_done(arr_done), .arr_result(arr_result),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // SRAM the sequencer drives (environment), plus the bench's own expected image.
  logic [DW-1:0] mem     [1<<AW];
  logic [DW-1:0] ref_mem [1<<AW];

  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    sram_rdata <= mem[sram_addr];
  end

  int      n_tests = 0;
  int      n_fail  = 0;
  logic    exp_err = 1'b0;
  logic [AW-1:0] blk_addr = '0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk_eq("err", 64'(err), 64'(exp_err));
  endtask

  function automatic logic [AW-1:0] a_act(input logic [AW-1:0] base, input int t, input int r, input int j);
    return AW'((int'(base) + t * NN + r * N + j) % (1 << AW));
  endfunction

  function automatic logic [AW-1:0] a_wgt(input logic [AW-1:0] base, input int r, input int j);
    return AW'((int'(base) + r * N + j) % (1 << AW));
  endfunction

  task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_addr = a; host_wdata = d; host_we = 1'b1;
    tick();
    host_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic host_rd(input logic [AW-1:0] a);
    host_addr = a;
    tick();
    chk_eq("host_rd", 64'(host_rdata), 64'(ref_mem[a]));
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_busy"},  64'(busy), 64'(0));
    chk_eq({tag, "_done"},  64'(done), 64'(0));
    chk_eq({tag, "_err"},   64'(err), 64'(0));
    chk_eq({tag, "_valid"}, 64'(arr_load_valid), 64'(0));
    chk_eq({tag, "_start"}, 64'(arr_start), 64'(0));
    chk_eq({tag, "_act"},   64'(arr_act_row), 64'(0));
    chk_eq({tag, "_wgt"},   64'(arr_wgt_row), 64'(0));
    chk_eq({tag, "_we"},    64'(sram_we), 64'(0));
  endtask

  // One command, checked cycle by cycle against addresses/rows/words derived
  // from the command fields and ref_mem. abort_i >= 0 resets mid write-back.
  task automatic run_cmd(input logic [AW-1:0] ab, input logic [AW-1:0] wb, input logic [AW-1:0] ob,
                         input int nt, input bit host_in_wait, input bit start_in_load, input int abort_i);
    logic [N*DW-1:0]  ea, ew;
    logic [NN*DW-1:0] res;
    logic [AW-1:0]    wa;
    int               d;
    bit               ev;
    act_base = ab; wgt_base = wb; out_base = ob; num_tiles = 8'(nt);
    start = 1'b1;
    exp_err = 1'b0;
    tick();
    start = 1'b0;
    for (int t = 0; t < nt; t++) begin
      for (int c = 0; c < LOADC; c++) begin
        if (c < RD) begin
          int r, p;
          r = c / (2 * N);
          p = c % (2 * N);
          chk_eq("rd_addr", 64'(sram_addr), 64'((p < N) ? a_act(ab, t, r, p) : a_wgt(wb, r, p - N)));
          chk_eq("rd_we", 64'(sram_we), 64'(0));
        end
        ev = (c >= 2 * N + 1) && (((c - 1) % (2 * N)) == 0);
        chk_eq("ld_valid", 64'(arr_load_valid), 64'(ev));
        if (ev) begin
          int r;
          r = (c - 1) / (2 * N) - 1;
          for (int j = 0; j < N; j++) begin
            ea[j*DW +: DW] = ref_mem[a_act(ab, t, r, j)];
            ew[j*DW +: DW] = ref_mem[a_wgt(wb, r, j)];
          end
          chk_eq("act_row", 64'(arr_act_row), 64'(ea));
          chk_eq("wgt_row", 64'(arr_wgt_row), 64'(ew));
        end
        chk_eq("ld_start", 64'(arr_start), 64'(0));
        chk_eq("ld_busy", 64'(busy), 64'(1));
        // stray completion pulse and a second command while loading
        arr_done = (c == 1);
        if (c == 1) arr_result = {$urandom, $urandom};
        if (start_in_load && t == 0) begin
          start = (c == 2);
          if (c == 2) begin
            act_base = AW'($urandom); out_base = AW'($urandom); num_tiles = 8'($urandom_range(0, 5));
          end
        end
        tick();
      end
      start = 1'b0;
      chk_eq("fire_start", 64'(arr_start), 64'(1));
      chk_eq("fire_valid", 64'(arr_load_valid), 64'(0));
      chk_eq("fire_we", 64'(sram_we), 64'(0));
      tick();
      d = $urandom_range(0, 3);
      if (host_in_wait && t == 0 && d == 0) d = 1;
      for (int w = 0; w < d; w++) begin
        chk_eq("wait_start", 64'(arr_start), 64'(0));
        chk_eq("wait_we", 64'(sram_we), 64'(0));
        if (host_in_wait && t == 0 && w == 0) begin
          blk_addr = AW'($urandom);
          host_addr = blk_addr; host_wdata = DW'($urandom); host_we = 1'b1;
          #1 chk_eq("host_blk", 64'(sram_we), 64'(0));
          exp_err = 1'b1;
        end
        tick();
        host_we = 1'b0;
      end
      res = {$urandom, $urandom};
      arr_result = res;
      arr_done = 1'b1;
      tick();
      arr_done = 1'b0;
      for (int i = 0; i < NN; i++) begin
        if (t == 0 && i == abort_i) begin
          rst_n = 1'b0;
          arr_done = 1'b0;
          exp_err = 1'b0;
          #1 chk_all_zero("rst");
          chk_eq("rst_addr", 64'(sram_addr), 64'(host_addr));
          tick();
          rst_n = 1'b1;
          tick();
          chk_all_zero("post_rst");
          return;
        end
        wa = AW'((int'(ob) + t * NN + i) % (1 << AW));
        chk_eq("wb_we", 64'(sram_we), 64'(1));
        chk_eq("wb_addr", 64'(sram_addr), 64'(wa));
        chk_eq("wb_data", 64'(sram_wdata), 64'(res[i*DW +: DW]));
        ref_mem[wa] = res[i*DW +: DW];
        arr_done = (i == 0);
        if (i == 0) arr_result = ~res;
        tick();
      end
    end
    chk_eq("dn_busy", 64'(busy), 64'(1));
    chk_eq("dn_early", 64'(done), 64'(0));
    chk_eq("dn_we", 64'(sram_we), 64'(0));
    chk_eq("dn_start", 64'(arr_start), 64'(0));
    tick();
    chk_eq("done", 64'(done), 64'(1));
    chk_eq("idle_busy", 64'(busy), 64'(0));
    tick();
    chk_eq("done_pulse", 64'(done), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // basic single tile
    for (int i = 0; i < 4; i++) host_wr(AW'(i), DW'(i + 1));
    for (int i = 0; i < 4; i++) host_wr(AW'(16 + i), DW'(i + 5));
    host_rd(AW'(2));
    host_rd(AW'(19));
    run_cmd(AW'(0), AW'(16), AW'(32), 1, 1'b0, 1'b0, -1);

    // three tiles, shared weights
    for (int i = 0; i < 12; i++) host_wr(AW'(i), DW'($urandom));
    run_cmd(AW'(0), AW'(16), AW'(32), 3, 1'b0, 1'b0, -1);

    // zero tiles
    run_cmd(AW'(5), AW'(6), AW'(7), 0, 1'b0, 1'b0, -1);

    // host collision in WAIT and ignored restart in LOAD
    run_cmd(AW'(64), AW'(80), AW'(96), 2, 1'b1, 1'b1, -1);
    repeat (3) tick();
    host_rd(blk_addr);
    host_wr(AW'(200), DW'(16'h1234));
    host_rd(AW'(200));

    // address wrap
    run_cmd(AW'(10'h3FE), AW'(10'h100), AW'(10'h200), 1, 1'b0, 1'b0, -1);

    // reset mid write-back, then a fresh command
    run_cmd(AW'(0), AW'(16), AW'(48), 2, 1'b1, 1'b0, 2);
    run_cmd(AW'(0), AW'(16), AW'(48), 1, 1'b0, 1'b0, -1);

    for (int k = 0; k < 12; k++) begin
      int ab_i;
      ab_i = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NN - 1)) : -1;
      host_wr(AW'($urandom), DW'($urandom));
      run_cmd(AW'($urandom), AW'($urandom), AW'($urandom), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ab_i);
    end

    for (int i = 0; i < 8; i++) host_rd(AW'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
